demux3_16b_router: RTL and testbench
====================================

Name: demux3_16b_router

Overview:
- Registered 1-to-3 router for 16-bit words. It is the distribution counterpart of the datapath's 3-input select muxes.
- Takes one word plus a 2-bit destination select on a valid/ready input, and delivers it to one of three valid/ready output channels.
- Each channel has its own one-entry holding register, so the channels drain independently.
- Sits between producer stages (ALU/memory writeback) and their three consumers.

Parameters:
- WIDTH, 16, data width per channel.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  WIDTH  word to route.
- in_sel  in  2  destination: 0→ch0, 1→ch1, 2→ch2, 3→illegal.
- in_valid  in  1  in_data/in_sel valid.
- in_ready  out  1  router accepts this cycle.
- out_data  out  3*WIDTH  channel k on bits [WIDTH*k+WIDTH-1 : WIDTH*k].
- out_valid  out  3  per-channel word valid.
- out_ready  in  3  per-channel consumer ready.
- err_illegal  out  1  sticky: an in_sel==3 word was accepted and dropped.
- err_clr  in  1  synchronous clear of err_illegal.
- stat_count  out  48  per-channel delivered-word counters (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=3'b000, out_data=0, err_illegal=0, stat_count=0. Any word in flight is discarded.
- After reset release: state is idle; first acceptance possible on the first rising edge with reset_n high.
- in_ready is combinational from in_sel, out_valid and out_ready:
  - in_sel==3 → 1.
  - otherwise → !out_valid[in_sel] | out_ready[in_sel].
  - No combinational path from in_data.
- Accept = in_valid & in_ready, sampled at the rising edge.
- Per-channel FSM, states EMPTY / FULL:
  - EMPTY → FULL: accept with in_sel==k. Load in_data; out_valid[k]=1 next cycle.
  - FULL → EMPTY: out_ready[k] & no accept to k.
  - FULL → FULL with new data: out_ready[k] & accept to k in the same cycle (simultaneous drain + load). No bubble.
  - FULL, out_ready[k]==0: out_data slice and out_valid[k] held stable.
- Latency: accept at edge N → out_valid[k]=1 after edge N. Throughput 1 word/cycle per channel.
- Channels are independent: a stalled channel blocks only inputs addressed to it (head-of-line at the input, by design).
- Per-channel order is preserved.
- Illegal select (in_sel==3):
  - Word accepted and discarded; no channel changes.
  - err_illegal=1 from the next cycle.
  - err_illegal stays set until err_clr=1 at an edge.
  - If err_clr and a new illegal accept coincide, the set wins.
- in_valid low: no state change except drains.
- in_sel/in_data are don't-care when in_valid=0.
- Drain-only outputs: out_valid deasserts on the edge where out_ready[k]=1, unless reloaded in that same cycle.

Optional Feature:
- Macro: DEMUX3_STATS_EN.
- Defined:
  - Three WIDTH-bit counters.
  - Counter k increments on each out_valid[k] & out_ready[k] edge.
  - Counters wrap from 0xFFFF to 0x0000.
  - Cleared only by reset.
  - Driven on stat_count slice k.
- Undefined: no counter logic is built; stat_count is tied to 0.

Decomposition:
- Package demux3_pkg:
  - DATA_W=16.
  - NCH=3.
  - SEL_ILLEGAL=2'd3.
  - enum chan_state_t {CH_EMPTY, CH_FULL}.
- Sub-module demux_chan_reg:
  - One channel's holding register, state FSM and optional counter.
  - Ports: load, load_data, ready, valid, data, count.
  - Instantiated NCH times by the top level. The top level holds select decode, in_ready and err_illegal.

Test Plan:
- Reset mid-transfer:
  - Stimulus: load ch1 with 0xBEEF, then assert reset_n=0 while out_ready=0 for 2 cycles.
  - Response: out_valid=000 and out_data=0 immediately (asynchronous); no output after release.
- Basic routing:
  - Stimulus: in_sel=0/1/2 with data 0x1111/0x2222/0x3333 on consecutive cycles; out_ready=111.
  - Response: each word appears 1 cycle later on its own slice; out_valid one-hot per cycle.
- Backpressure and simultaneous load:
  - Stimulus: ch2 holds 0xAAAA with out_ready[2]=0; present 0x5555 to ch2.
  - Response: in_ready=0 and 0xAAAA stays stable.
  - Stimulus: raise out_ready[2].
  - Response: in the same cycle in_ready=1, 0xAAAA delivered, next cycle 0x5555 valid with no gap.
- Channel independence:
  - Stimulus: ch0 stalled (full, out_ready[0]=0); send 0x0C0C to ch1.
  - Response: accepted immediately; delivered while ch0 stays full.
- Illegal select:
  - Stimulus: in_sel=3, data 0xDEAD.
  - Response: in_ready=1, no out_valid change, err_illegal=1 next cycle.
  - Stimulus: err_clr pulse.
  - Response: err_illegal=0.
  - Stimulus: err_clr together with another illegal accept.
  - Response: err_illegal stays 1.
- With DEMUX3_STATS_EN:
  - Stimulus: 65537 words to ch0.
  - Response: stat_count[15:0]=1 (wrapped); other slices 0.
  - Without the macro: stat_count=0 throughout.

Source files
------------

// File: rtl/demux3_pkg.sv
// Shared constants and channel state type for the 1-to-3 word router.
package demux3_pkg;

  localparam int DATA_W = 16;
  localparam int NCH    = 3;

  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_t;

  function automatic logic sel_hits(input logic [1:0] sel, input int k);
    return sel == 2'(k);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: single-entry holding register with EMPTY/FULL FSM and an
// optional delivered-word counter (built only when DEMUX3_STATS_EN is defined).
module demux_chan_reg
  import demux3_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output chan_state_t      state
);

  chan_state_t      state_q;
  chan_state_t      state_d;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A load while FULL only happens when the consumer is draining, so
  // FULL stays FULL with the new word and no bubble is inserted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_EMPTY: if (load) state_d = CH_FULL;
      CH_FULL:  if (ready && !load) state_d = CH_EMPTY;
      default:  state_d = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  assign valid = (state_q == CH_FULL);
  assign data  = data_q;
  assign state = state_q;

`ifdef DEMUX3_STATS_EN
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (valid && ready) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

endmodule

// File: rtl/demux3_16b_router.sv
// Registered 1-to-3 valid/ready router; in_sel==3 words are dropped and flagged.
// Optional per-channel delivery counters are enabled with DEMUX3_STATS_EN.
module demux3_16b_router
  import demux3_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 err_illegal,
  input  logic                 err_clr,
  output logic [NCH*WIDTH-1:0] stat_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a held word stays stable
  // until it transfers.

  chan_state_t     chan_state [NCH];
  logic [NCH-1:0]  load;
  logic            accept;

  // Only the addressed channel can stall the input; illegal words always go.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (sel_hits(in_sel, k)) begin
        in_ready = (chan_state[k] != CH_FULL) || out_ready[k];
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = accept && sel_hits(in_sel, k);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[WIDTH*k +: WIDTH]),
      .count     (stat_count[WIDTH*k +: WIDTH]),
      .state     (chan_state[k])
    );
  end

  // A new illegal accept takes priority over a clear in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_illegal <= 1'b0;
    end else if (accept && (in_sel == SEL_ILLEGAL)) begin
      err_illegal <= 1'b1;
    end else if (err_clr) begin
      err_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux3_16b_router.sv
// Bench for demux3_16b_router: vector table, directed corner sequences and
// random traffic against a queue-based channel model.
module tb_demux3_16b_router;

  logic        clock;
  logic        reset_n;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic        err_illegal;
  logic        err_clr;
  logic [47:0] stat_count;

  demux3_16b_router dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_illegal (err_illegal),
    .err_clr     (err_clr),
    .stat_count  (stat_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard / model state
  logic [15:0] exp_q [3][$];
  logic [15:0] m_cnt [3];
  logic        m_err;
  int          total;
  int          bad;

  logic        obs_ready;
  logic [2:0]  obs_valid;
  logic [47:0] obs_data;

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic [15:0] d;
    logic [2:0]  r;
    logic        c;
    logic        er;
    logic [2:0]  ev;
    logic [47:0] ed;
    logic        eerr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] exp_stat();
`ifdef DEMUX3_STATS_EN
    return {m_cnt[2], m_cnt[1], m_cnt[0]};
`else
    return 48'h0;
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      m_cnt[k] = 16'h0;
    end
    m_err = 1'b0;
  endtask

  // Drive one cycle from a negedge: check outputs against the model, clock, update.
  task automatic step(input logic v, input logic [1:0] s, input logic [15:0] d,
                      input logic [2:0] r, input logic c);
    logic       exp_ready;
    logic [2:0] exp_valid;
    logic       acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    err_clr   = c;
    #1;
    if (s == 2'd3) exp_ready = 1'b1;
    else exp_ready = (exp_q[s].size() == 0) || r[s];
    for (int k = 0; k < 3; k++) exp_valid[k] = (exp_q[k].size() != 0);
    obs_ready = in_ready;
    obs_valid = out_valid;
    obs_data  = out_data;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    for (int k = 0; k < 3; k++) begin
      if (exp_valid[k]) check($sformatf("out_data[%0d]", k), out_data[16*k +: 16], exp_q[k][0]);
    end
    check("err_illegal", err_illegal, m_err);
    check("stat_count", stat_count, exp_stat());
    acc = v && exp_ready;
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      if (exp_q[k].size() != 0 && r[k]) begin
        void'(exp_q[k].pop_front());
        m_cnt[k] = m_cnt[k] + 16'h1;
      end
    end
    if (acc && s == 2'd3) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    if (acc && s != 2'd3) exp_q[s].push_back(d);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst out_valid", out_valid, 3'b000);
    check("rst out_data", out_data, 48'h0);
    check("rst err_illegal", err_illegal, 1'b0);
    check("rst stat_count", stat_count, 48'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    in_data = '0;
    in_sel = '0;
    in_valid = 1'b0;
    out_ready = '0;
    err_clr = 1'b0;
    model_clear();
    @(negedge clock);
    do_reset();

    //            v    s     d         r       c    er   ev      ed                              eerr
    vecs[0] = '{1'b1, 2'd0, 16'h1111, 3'b111, 1'b0, 1'b1, 3'b000, 48'h0,                         1'b0};
    vecs[1] = '{1'b1, 2'd1, 16'h2222, 3'b111, 1'b0, 1'b1, 3'b001, {16'h0, 16'h0, 16'h1111},      1'b0};
    vecs[2] = '{1'b1, 2'd2, 16'h3333, 3'b111, 1'b0, 1'b1, 3'b010, {16'h0, 16'h2222, 16'h0},      1'b0};
    vecs[3] = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b0, 1'b1, 3'b100, {16'h3333, 16'h0, 16'h0},      1'b0};
    vecs[4] = '{1'b1, 2'd3, 16'hDEAD, 3'b000, 1'b0, 1'b1, 3'b000, 48'h0,                         1'b0};
    vecs[5] = '{1'b0, 2'd0, 16'h0000, 3'b000, 1'b1, 1'b1, 3'b000, 48'h0,                         1'b1};
    vecs[6] = '{1'b1, 2'd3, 16'hBAD1, 3'b000, 1'b1, 1'b1, 3'b000, 48'h0,                         1'b0};
    vecs[7] = '{1'b0, 2'd0, 16'h0000, 3'b000, 1'b0, 1'b1, 3'b000, 48'h0,                         1'b1};
    vecs[8] = '{1'b0, 2'd0, 16'h0000, 3'b000, 1'b1, 1'b1, 3'b000, 48'h0,                         1'b1};
    vecs[9] = '{1'b0, 2'd0, 16'h0000, 3'b000, 1'b0, 1'b1, 3'b000, 48'h0,                         1'b0};

    for (int i = 0; i < 10; i++) begin
      logic [47:0] mask;
      in_valid  = vecs[i].v;
      in_sel    = vecs[i].s;
      in_data   = vecs[i].d;
      out_ready = vecs[i].r;
      err_clr   = vecs[i].c;
      #1;
      mask = {{16{vecs[i].ev[2]}}, {16{vecs[i].ev[1]}}, {16{vecs[i].ev[0]}}};
      check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].er);
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ev);
      check($sformatf("vec%0d out_data", i), out_data & mask, vecs[i].ed);
      check($sformatf("vec%0d err", i), err_illegal, vecs[i].eerr);
      step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r, vecs[i].c);
    end

    // backpressure, then simultaneous drain + load on ch2
    step(1'b1, 2'd2, 16'hAAAA, 3'b000, 1'b0);
    step(1'b1, 2'd2, 16'h5555, 3'b000, 1'b0);
    check("bp stalled in_ready", obs_ready, 1'b0);
    check("bp held data", obs_data[47:32], 16'hAAAA);
    step(1'b1, 2'd2, 16'h5555, 3'b100, 1'b0);
    check("bp release in_ready", obs_ready, 1'b1);
    check("bp deliver old", obs_data[47:32], 16'hAAAA);
    step(1'b0, 2'd0, 16'h0000, 3'b100, 1'b0);
    check("bp no gap valid", obs_valid, 3'b100);
    check("bp new data", obs_data[47:32], 16'h5555);

    // channel independence: ch0 stalled, ch1 still flows
    step(1'b1, 2'd0, 16'h7777, 3'b000, 1'b0);
    step(1'b1, 2'd1, 16'h0C0C, 3'b000, 1'b0);
    check("indep in_ready", obs_ready, 1'b1);
    step(1'b0, 2'd0, 16'h0000, 3'b010, 1'b0);
    check("indep valid", obs_valid, 3'b011);
    check("indep ch1 data", obs_data[31:16], 16'h0C0C);
    step(1'b0, 2'd0, 16'h0000, 3'b000, 1'b0);
    check("indep ch0 still full", obs_valid, 3'b001);
    step(1'b0, 2'd0, 16'h0000, 3'b001, 1'b0);

    // reset mid-transfer
    step(1'b1, 2'd1, 16'hBEEF, 3'b000, 1'b0);
    check("mid ch1 loaded", obs_valid, 3'b000);
    in_valid = 1'b0;
    out_ready = 3'b000;
    #1;
    check("mid ch1 valid", out_valid, 3'b010);
    do_reset();
    step(1'b0, 2'd0, 16'h0000, 3'b000, 1'b0);
    step(1'b0, 2'd0, 16'h0000, 3'b111, 1'b0);
    check("mid after release", obs_valid, 3'b000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
           3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
    end

`ifdef DEMUX3_STATS_EN
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      step(1'b1, 2'd0, 16'(i), 3'b001, 1'b0);
    end
    step(1'b0, 2'd0, 16'h0000, 3'b001, 1'b0);
    check("stats wrap", stat_count, {32'h0, 16'h0001});
`else
    check("stats tied off", stat_count, 48'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
